// File: rtl/svm_feature_loader.sv
// svm_feature_loader
// Streams raw signed samples in, quantizes each to NBITS (round-half-up,
// saturating) and builds an F_WIDTH-element feature vector. A complete frame
// is then offered to the classifier twice: valence first (out_sel=0), then
// arousal (out_sel=1). The vector is held stable across both transactions.
module svm_feature_loader #(
    parameter int NBITS       = 9,
    parameter int RAW_BITS    = 16,
    parameter int SHIFT       = 7,
    parameter int F_WIDTH     = 214,
    parameter int LOG_F_WIDTH = $clog2(F_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      raw_valid,
    output logic                      raw_ready,
    input  logic [RAW_BITS-1:0]       raw_feature,
    input  logic                      raw_last,
    output logic [NBITS*F_WIDTH-1:0]  out_features,
    output logic                      out_sel,
    output logic                      fout_valid,
    input  logic                      fout_ready,
    output logic                      len_err,
    output logic [15:0]               frames_sent
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEND_V = 2'd1,
        SEND_A = 2'd2
    } state_t;

    // Rounding offset and saturation bounds, all at the widened sum width.
    localparam logic signed [RAW_BITS:0] ROUND = (RAW_BITS+1)'(2**(SHIFT-1));
    localparam logic signed [RAW_BITS:0] Q_MAX = (RAW_BITS+1)'(2**(NBITS-1) - 1);
    localparam logic signed [RAW_BITS:0] Q_MIN = (RAW_BITS+1)'(-(2**(NBITS-1)));
    localparam logic [LOG_F_WIDTH-1:0]   LAST_IDX = LOG_F_WIDTH'(F_WIDTH - 1);

    state_t                   state_reg;
    state_t                   state_next;
    logic [LOG_F_WIDTH-1:0]   cnt_reg;
    logic                     len_err_reg;
    logic [15:0]              frames_sent_reg;
    logic [NBITS-1:0]         feat_reg [F_WIDTH];

    logic                     raw_fire;
    logic                     fout_fire;
    logic                     at_last;
    logic signed [RAW_BITS:0] sum;
    logic signed [RAW_BITS:0] q;
    logic [NBITS-1:0]         q_sat;

    assign raw_fire  = raw_valid && raw_ready;
    assign fout_fire = fout_valid && fout_ready;
    assign at_last   = (cnt_reg == LAST_IDX);

    // Quantizer: add half an LSB (sign-extended, one extra bit so it cannot
    // overflow), floor-shift, then clamp into the signed NBITS range.
    always_comb begin
        sum = $signed({raw_feature[RAW_BITS-1], raw_feature}) + ROUND;
        q   = sum >>> SHIFT;
        if (q > Q_MAX) begin
            q_sat = Q_MAX[NBITS-1:0];
        end else if (q < Q_MIN) begin
            q_sat = Q_MIN[NBITS-1:0];
        end else begin
            q_sat = q[NBITS-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a frame ends when the last index is written, whether or
    // not raw_last agreed; each send state waits for its own classifier fire.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL:    if (raw_fire && at_last) state_next = SEND_V;
            SEND_V:  if (fout_ready)          state_next = SEND_A;
            SEND_A:  if (fout_ready)          state_next = FILL;
            default:                          state_next = FILL;
        endcase
    end

    // Output decode: handshake signals depend on state only, never on fout_ready.
    always_comb begin
        raw_ready  = (state_reg == FILL) && !rst;
        fout_valid = (state_reg == SEND_V) || (state_reg == SEND_A);
        out_sel    = (state_reg == SEND_A);
    end

    // Index counter, length-error pulse and completed-frame counter. An early
    // raw_last drops the frame (counter back to 0); a missing raw_last on the
    // final index is flagged but the frame still goes out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg         <= '0;
            len_err_reg     <= 1'b0;
            frames_sent_reg <= '0;
        end else begin
            len_err_reg <= raw_fire && (at_last ^ raw_last);
            if (raw_fire) begin
                if (at_last || raw_last) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            if (fout_fire && (state_reg == SEND_A)) begin
                frames_sent_reg <= frames_sent_reg + 16'd1;
            end
        end
    end

    // One register per feature slot, written only while filling, so the vector
    // cannot change while a transaction is being offered.
    generate
        for (genvar gi = 0; gi < F_WIDTH; gi++) begin : g_feat
            // Capture the quantized sample when the fill index points here.
            always_ff @(posedge clk) begin
                if (rst) begin
                    feat_reg[gi] <= '0;
                end else if (raw_fire && (cnt_reg == LOG_F_WIDTH'(gi))) begin
                    feat_reg[gi] <= q_sat;
                end
            end
            assign out_features[gi*NBITS +: NBITS] = feat_reg[gi];
        end
    endgenerate

    assign len_err     = len_err_reg;
    assign frames_sent = frames_sent_reg;

endmodule

// File: doc/svm_feature_loader.md
# svm_feature_loader

Upstream feeder for the SVM classifier. Accepts raw signed feature samples one per cycle on a valid/ready stream and quantizes each to NBITS with round-half-up and saturation. Assembles the F_WIDTH-element feature vector and presents it to the classifier as two back-to-back transactions: valence first, then arousal. `out_sel` tells the support/alpha/intercept memory mux which class set to drive alongside each transaction.

## Interface
- NBITS, 9, quantized feature width (signed)
- RAW_BITS, 16, raw sample width (signed)
- SHIFT, 7, right-shift applied during quantization (must be ≥1)
- F_WIDTH, 214, features per frame
- LOG_F_WIDTH, ceilLog2(F_WIDTH), index counter width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- raw_valid  in  1  raw sample valid
- raw_ready  out  1  loader accepts a raw sample
- raw_feature  in  RAW_BITS  signed raw sample
- raw_last  in  1  marks final sample of a frame
- out_features  out  NBITS*F_WIDTH  packed vector; feature i at [i*NBITS +: NBITS]
- out_sel  out  1  0 = valence transaction, 1 = arousal transaction
- fout_valid  out  1  vector valid toward classifier
- fout_ready  in  1  classifier ready (its fin_ready)
- len_err  out  1  one-cycle pulse on frame-length mismatch
- frames_sent  out  16  count of completed frames (both transactions done), wraps

## Operation
- States: FILL, SEND_V, SEND_A.
- Reset: state=FILL, index cnt=0, out_features=0, out_sel=0, fout_valid=0, len_err=0, frames_sent=0. raw_ready=0 while rst is high.
- raw_ready = (state==FILL) && !rst.
- fout_valid = state is SEND_V or SEND_A.
- out_sel = (state==SEND_A).
- Quantize step:
  - sum = raw_feature + 2^(SHIFT-1), computed sign-extended in RAW_BITS+1 bits.
  - q = sum >>> SHIFT (arithmetic shift, floor).
  - Saturate q to [-2^(NBITS-1), 2^(NBITS-1)-1].
- FILL, on raw fire:
  - Write q into feature[cnt].
  - If cnt < F_WIDTH-1 and raw_last=0: cnt++.
  - If cnt < F_WIDTH-1 and raw_last=1 (early last): pulse len_err, drop frame, cnt←0, stay FILL. Already-written entries are not cleared; they are overwritten by the next frame.
  - If cnt == F_WIDTH-1: cnt←0, go to SEND_V. If raw_last=0 on this sample, pulse len_err but still send the frame.
- SEND_V: on fout fire, go to SEND_A. out_features is held stable.
- SEND_A: on fout fire, go to FILL and increment frames_sent (wraps 0xFFFF→0).
- out_features changes only in FILL; it is stable whenever fout_valid=1.
- Raw samples are never accepted while in SEND_V or SEND_A.
- Reset mid-frame or mid-send: return to the reset state immediately and discard the partial frame. No further fout_valid until a full new frame is accepted.

## Timing
- Final sample accepted at edge t: fout_valid=1, out_sel=0 from cycle t+1.
- fout_valid is asserted independently of fout_ready. Once asserted, it stays asserted with stable data until the fire.
- Valence fire at edge t: out_sel=1 from cycle t+1, fout_valid stays 1.
- Arousal fire at edge t: raw_ready=1 from cycle t+1. frames_sent updates at edge t.
- Minimum frame period: F_WIDTH + 2 cycles when fout_ready is held at 1.
- len_err is registered: high for exactly the cycle after the offending sample's fire.
- Classifier stall between transactions (it only becomes ready after computing valence) is absorbed by holding SEND_A.

## Test plan
- Quantization, bench F_WIDTH=4, NBITS=9, SHIFT=7. Input frame 1000, -1000, 64, 63 with last on the 4th sample → out_features elements 8, -8, 1, 0. fout_valid rises 1 cycle after the 4th fire, with out_sel=0.
- Saturation: input 32767, -32768, 32704, -32705 → 255, -256, 255, -256. len_err stays 0.
- Two-phase handshake: hold fout_ready=0 for 5 cycles, then pulse it for 1 cycle, then hold it 0 for 20 cycles, then pulse it again. Required: valid held and data stable throughout; out_sel changes 0→1 after the first pulse; raw_ready=0 until after the second fire; frames_sent=1.
- Early last: raw_last asserted on the 2nd sample → len_err pulse, no fout_valid. The next correct 4-sample frame is sent with its own values only.
- Missing last: 4 samples with raw_last=0 → len_err pulse and the frame is still sent. A 5th raw_valid presented during SEND_V is not accepted.
- Reset mid-send: assert rst in SEND_A → next cycle fout_valid=0, raw_ready=0 while rst is high, frames_sent=0, out_features=0. Normal operation resumes after rst deasserts.
